// File: rtl/serial_adder_param.sv
// Multi-cycle adder: sums two WIDTH-bit operands plus carry-in, DIGIT bits per clock,
// with a start/busy/done handshake. Results load only on the edge that enters DONE.
module serial_adder_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $fatal(1, "serial_adder_param: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, psum_reg, psum_next;
  logic             carry_reg, a_msb_reg, b_msb_reg;
  logic [CW-1:0]    count_reg;
  logic [DIGIT:0]   dsum;
  logic             last, accept, ovf_final;

  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign last   = (count_reg == CW'(N - 1));
  assign accept = start && (state_reg == IDLE || state_reg == DONE);

  // One digit of the addition; its result enters the partial sum from the top.
  always_comb begin
    dsum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + (DIGIT+1)'(carry_reg);
    psum_next = psum_reg >> DIGIT;
    psum_next[WIDTH-1 -: DIGIT] = dsum[DIGIT-1:0];
    ovf_final = (a_msb_reg == b_msb_reg) && (psum_next[WIDTH-1] != a_msb_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      psum_reg  <= '0;
      carry_reg <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      count_reg <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      psum_reg  <= '0;
      carry_reg <= cin;
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
      count_reg <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> DIGIT;
      b_reg     <= b_reg >> DIGIT;
      psum_reg  <= psum_next;
      carry_reg <= dsum[DIGIT];
      count_reg <= count_reg + CW'(1);
      if (last) begin
        sum      <= psum_next;
        cout     <= dsum[DIGIT];
        overflow <= ovf_final;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_param.sv
// Directed bench for serial_adder_param: one bit-serial (DIGIT=1) and one
// nibble-serial (DIGIT=4) instance, table vectors plus handshake corner sequences.
module tb_serial_adder_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start1, cin1, busy1, done1, cout1, ovf1;
  logic [7:0] a1, b1, sum1;
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [7:0] a4, b4, sum4;

  serial_adder_param #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));

  serial_adder_param #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4));

  bit         sel4;
  logic       o_busy, o_done, o_cout, o_ovf;
  logic [7:0] o_sum;
  assign o_busy = sel4 ? busy4 : busy1;
  assign o_done = sel4 ? done4 : done1;
  assign o_sum  = sel4 ? sum4  : sum1;
  assign o_cout = sel4 ? cout4 : cout1;
  assign o_ovf  = sel4 ? ovf4  : ovf1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         sel4;
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, input logic st);
    if (sel4) begin a4 = ta; b4 = tb_v; cin4 = tc; start4 = st; end
    else      begin a1 = ta; b1 = tb_v; cin1 = tc; start1 = st; end
  endtask

  // Counts RUN cycles from the current negedge until done, bounded.
  task automatic wait_done(input string nm, input int en, input bit chk_hold, input logic [7:0] hold_s);
    int nb;
    nb = 0;
    while (o_busy && nb < 50) begin
      if (chk_hold) chk({nm, " hold"}, 32'(o_sum), 32'(hold_s));
      nb++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, nb, en);
    chk({nm, " done"}, 32'(o_done), 1);
  endtask

  task automatic chk_res(input string nm, input logic [7:0] s, input logic co, input logic ov);
    chk({nm, " sum"}, 32'(o_sum), 32'(s));
    chk({nm, " cout"}, 32'(o_cout), 32'(co));
    chk({nm, " ovf"}, 32'(o_ovf), 32'(ov));
  endtask

  // Single start pulse; operands are scrambled right after the start edge.
  task automatic run_op(input string nm, input vec_t v, input bit chk_hold, input logic [7:0] hold_s);
    sel4 = v.sel4;
    @(negedge clk);
    drive(v.a, v.b, v.cin, 1'b1);
    @(negedge clk);
    drive(~v.a, ~v.b, ~v.cin, 1'b0);
    wait_done(nm, v.sel4 ? 2 : 8, chk_hold, hold_s);
    chk_res(nm, v.s, v.co, v.ov);
    @(negedge clk);
    chk({nm, " done_pulse_end"}, 32'(o_done), 0);
    chk({nm, " sum_held"}, 32'(o_sum), 32'(v.s));
  endtask

  logic [7:0] last_s[2];
  int         t, npulse;

  initial begin
    vecs[0] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{0, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[5] = '{1, 8'hA5, 8'h5B, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[6] = '{1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[7] = '{1, 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[8] = '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst = 1'b1;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    sel4 = 0;
    #1;
    chk("reset busy1", 32'(busy1), 0);
    chk("reset done1", 32'(done1), 0);
    chk("reset sum1", 32'(sum1), 0);
    chk("reset busy4", 32'(busy4), 0);
    chk("reset sum4", 32'(sum4), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_s[0] = 8'h00;
    last_s[1] = 8'h00;

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i], 1'b1, last_s[vecs[i].sel4]);
      last_s[vecs[i].sel4] = vecs[i].s;
    end

    // Start during RUN must be ignored and operand changes must not matter.
    sel4 = 0;
    @(negedge clk);
    drive(8'h10, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h10, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'hFF, 8'hFF, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h55, 8'hAA, 1'b1, 1'b0);
    wait_done("ign", 6, 1'b1, 8'hFF);
    chk_res("ign", 8'h30, 1'b0, 1'b0);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_done || o_busy) npulse++;
    end
    chk("ign extra_activity", npulse, 0);

    // Async reset in the 4th RUN cycle, after a result with cout=1.
    run_op("pre_rst", vecs[8], 1'b0, 8'h00);
    @(negedge clk);
    drive(8'h01, 8'h02, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h01, 8'h02, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst pre_busy", 32'(o_busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst busy", 32'(o_busy), 0);
    chk("rst done", 32'(o_done), 0);
    chk_res("rst", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_done || o_busy) npulse++;
    end
    chk("rst no_done", npulse, 0);
    run_op("post_rst", '{0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0}, 1'b1, 8'h00);

    // Back-to-back with start held high; next operands presented in DONE.
    sel4 = 0;
    @(negedge clk);
    drive(8'h01, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    wait_done("b2b1", 8, 1'b0, 8'h00);
    chk_res("b2b1", 8'h02, 1'b0, 1'b0);
    drive(8'h02, 8'h02, 1'b0, 1'b1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!o_done && t < 30);
    chk("b2b spacing", t, 9);
    drive(8'h02, 8'h02, 1'b0, 1'b0);
    chk_res("b2b2", 8'h04, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b idle_busy", 32'(o_busy), 0);
    chk("b2b idle_done", 32'(o_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
